// File: rtl/vga_draw_pkg.sv
// Shared types and default geometry for the VGA pixel-draw arbiter.
package vga_draw_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam int X_W_DEF      = 9;
  localparam int Y_W_DEF      = 8;
  localparam int COLOR_W_DEF  = 3;

endpackage

// File: rtl/vga_draw_arbiter_rr.sv
// Combinational round-robin picker: scans from the channel after ptr_i, wrapping at NUM_CH.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  int c;

  always_comb begin
    // NOTE: every output gets a default before the loop, so no latch is inferred.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = int'(ptr_i) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!valid_o && req_i[c[IDX_W-1:0]]) begin
        valid_o                 = 1'b1;
        grant_o[c[IDX_W-1:0]]   = 1'b1;
        idx_o                   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Multiplexes NUM_CH pixel writers and a full-screen fill onto one VGA write port.
// Define DRAW_BOUNDS_CHECK_EN to suppress plotting of off-screen granted pixels.
module vga_draw_arbiter
  import vga_draw_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*X_W-1:0]     x_in,
  input  logic [NUM_CH*Y_W-1:0]     y_in,
  input  logic [NUM_CH*COLOR_W-1:0] color_in,
  output logic [NUM_CH-1:0]         grant,
  input  logic                      clear_start,
  input  logic [COLOR_W-1:0]        clear_color,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      plot,
  output logic [X_W-1:0]            x,
  output logic [Y_W-1:0]            y,
  output logic [COLOR_W-1:0]        colour
);

  localparam int IDX_W = $clog2(NUM_CH);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 plot_q, plot_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   col_q, col_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [X_W-1:0]       cnt_x_q, cnt_x_d;
  logic [Y_W-1:0]       cnt_y_q, cnt_y_d;
  logic [COLOR_W-1:0]   fill_col_q, fill_col_d;

  logic [NUM_CH-1:0]    arb_req;
  logic [NUM_CH-1:0]    gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [X_W-1:0]       x_sel;
  logic [Y_W-1:0]       y_sel;
  logic [COLOR_W-1:0]   col_sel;

  // Requests are only visible to the picker in ARB when no fill is being accepted.
  assign arb_req = (state_q == ARB && !clear_start) ? req : '0;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_rr (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  always_comb begin
    x_sel   = '0;
    y_sel   = '0;
    col_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        x_sel   = x_in[i*X_W +: X_W];
        y_sel   = y_in[i*Y_W +: Y_W];
        col_sel = color_in[i*COLOR_W +: COLOR_W];
      end
    end
  end

`ifdef DRAW_BOUNDS_CHECK_EN
  logic in_bounds;
  assign in_bounds = (32'(x_sel) < SCREEN_W) && (32'(y_sel) < SCREEN_H);
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    plot_d     = 1'b0;
    x_d        = x_q;
    y_d        = y_q;
    col_d      = col_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_x_d    = cnt_x_q;
    cnt_y_d    = cnt_y_q;
    fill_col_d = fill_col_q;
    unique case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d    = CLEAR;
          fill_col_d = clear_color;
          busy_d     = 1'b1;
          cnt_x_d    = '0;
          cnt_y_d    = '0;
        end else if (gnt_valid) begin
          ptr_d = gnt_idx;
          x_d   = x_sel;
          y_d   = y_sel;
          col_d = col_sel;
`ifdef DRAW_BOUNDS_CHECK_EN
          plot_d = in_bounds;
`else
          plot_d = 1'b1;
`endif
        end
      end
      CLEAR: begin
        plot_d = 1'b1;
        x_d    = cnt_x_q;
        y_d    = cnt_y_q;
        col_d  = fill_col_q;
        if (cnt_x_q == X_W'(SCREEN_W - 1)) begin
          cnt_x_d = '0;
          if (cnt_y_q == Y_W'(SCREEN_H - 1)) begin
            cnt_y_d = '0;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_y_d = cnt_y_q + 1'b1;
          end
        end else begin
          cnt_x_d = cnt_x_q + 1'b1;
        end
      end
      DONE:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ARB;
      ptr_q      <= IDX_W'(NUM_CH - 1);
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_x_q    <= '0;
      cnt_y_q    <= '0;
      fill_col_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      plot_q     <= plot_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_x_q    <= cnt_x_d;
      cnt_y_q    <= cnt_y_d;
      fill_col_q <= fill_col_d;
    end
  end

  assign grant      = gnt;
  assign plot       = plot_q;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = col_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule
